// File: rtl/fifo_flagged_if.sv
// Handshake bundle between a producer/consumer and fifo_flagged.
// The master modport is the side that issues writes, reads and flushes.
interface fifo_flagged_if #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic             flush;
   logic             write;
   logic [WIDTH-1:0] data_in;
   logic             read;
   logic [WIDTH-1:0] data_out;
   logic             full;
   logic             almost_full;
   logic             empty;
   logic             almost_empty;
   logic [CW-1:0]    count;
   logic             overflow;
   logic             underflow;

   modport master (
      output flush, write, data_in, read,
      input  data_out, full, almost_full, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  flush, write, data_in, read,
      output data_out, full, almost_full, empty, almost_empty, count, overflow, underflow
   );
endinterface

// File: rtl/fifo_flagged.sv
// Single-clock FIFO using every slot (extra pointer bit), with occupancy count,
// programmable almost flags, sticky error flags, sync flush and FWFT/registered read.
module fifo_flagged #(
   parameter int WIDTH    = 16,
   parameter int DEPTH    = 16,
   parameter int AF_LEVEL = DEPTH - 2,
   parameter int AE_LEVEL = 2,
   parameter bit FWFT     = 1'b1
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_flagged_if.slave bus
);
   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] AF_L = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AE_L = PW'(AE_LEVEL);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    count;
   logic             full;
   logic             empty;
   logic             rd_ok;
   logic             wr_ok;
   logic             overflow;
   logic             underflow;
   logic [AW-1:0]    rd_addr;

   assign rd_addr = rd_ptr[AW-1:0];
   assign count   = wr_ptr - rd_ptr;
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   // A full FIFO still takes a write when a read frees a slot in the same cycle.
   assign rd_ok = bus.read & ~empty;
   assign wr_ok = bus.write & (~full | rd_ok);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else if (bus.flush) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_ok)
            rd_ptr <= rd_ptr + 1'b1;
         if (bus.write && !wr_ok)
            overflow <= 1'b1;
         if (bus.read && !rd_ok)
            underflow <= 1'b1;
      end
   end

   // Storage carries no reset so it can map onto block RAM.
   always_ff @(posedge clk) begin
      if (wr_ok && !bus.flush)
         mem[wr_ptr[AW-1:0]] <= bus.data_in;
   end

   generate
      if (FWFT) begin : g_fwft
         assign bus.data_out = mem[rd_addr];
      end else begin : g_reg
         logic [WIDTH-1:0] data_reg;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               data_reg <= '0;
            else if (rd_ok && !bus.flush)
               data_reg <= mem[rd_addr];
         end
         assign bus.data_out = data_reg;
      end
   endgenerate

   assign bus.count        = count;
   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (count >= AF_L);
   assign bus.almost_empty = (count <= AE_L);
   assign bus.overflow     = overflow;
   assign bus.underflow    = underflow;
endmodule

// File: tb/tb_fifo_flagged.sv
// Drives an FWFT and a registered-read instance with identical stimulus; a
// scoreboard queue per instance is checked by monitors as read data appears.
module tb_fifo_flagged;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   fifo_flagged_if #(.WIDTH(16), .DEPTH(16)) if1 ();
   fifo_flagged_if #(.WIDTH(16), .DEPTH(16)) if0 ();

   fifo_flagged #(.WIDTH(16), .DEPTH(16), .FWFT(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
   fifo_flagged #(.WIDTH(16), .DEPTH(16), .FWFT(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

   int errors = 0;
   int checks = 0;

   logic [15:0] model_q [$];
   logic [15:0] exp1 [$];
   logic [15:0] exp0 [$];
   bit m_ovf = 1'b0;
   bit m_unf = 1'b0;
   bit pend0 = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, req);
      end else
         $display("ok   %s: %h", name, act);
   endtask

   // One clock of stimulus; the model decides acceptance and queues expected reads.
   task automatic step(input bit w, input logic [15:0] d, input bit r, input bit f);
      bit racc, wacc;
      if1.write = w; if1.data_in = d; if1.read = r; if1.flush = f;
      if0.write = w; if0.data_in = d; if0.read = r; if0.flush = f;
      if (f) begin
         model_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         racc = r && (model_q.size() > 0);
         wacc = w && ((model_q.size() < 16) || racc);
         if (racc) begin
            exp1.push_back(model_q[0]);
            exp0.push_back(model_q[0]);
            void'(model_q.pop_front());
         end
         if (wacc) model_q.push_back(d);
         if (w && !wacc) m_ovf = 1'b1;
         if (r && !racc) m_unf = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      step(1'b0, 16'h0000, 1'b0, 1'b0);
   endtask

   // FWFT: head is visible in the same cycle the read is presented.
   always @(negedge clk) begin
      if (rst_n && if1.read && !if1.empty && !if1.flush) begin
         checks++;
         if (exp1.size() == 0) begin
            errors++;
            $display("FAIL fwft_read: got %h expected no read data", if1.data_out);
         end else begin
            logic [15:0] e;
            e = exp1.pop_front();
            if (if1.data_out !== e) begin
               errors++;
               $display("FAIL fwft_read: got %h expected %h", if1.data_out, e);
            end else
               $display("ok   fwft_read: %h", e);
         end
      end
   end

   // Registered read: data is valid one cycle after the accepted read.
   always @(negedge clk) begin
      if (pend0) begin
         checks++;
         if (exp0.size() == 0) begin
            errors++;
            $display("FAIL reg_read: got %h expected no read data", if0.data_out);
         end else begin
            logic [15:0] e;
            e = exp0.pop_front();
            if (if0.data_out !== e) begin
               errors++;
               $display("FAIL reg_read: got %h expected %h", if0.data_out, e);
            end else
               $display("ok   reg_read: %h", e);
         end
      end
      pend0 = rst_n && if0.read && !if0.empty && !if0.flush;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      if1.write = 0; if1.read = 0; if1.flush = 0; if1.data_in = '0;
      if0.write = 0; if0.read = 0; if0.flush = 0; if0.data_in = '0;

      // Reset with no clock edge yet
      #2;
      chk("rst_empty", 32'(if1.empty), 1);
      chk("rst_full", 32'(if1.full), 0);
      chk("rst_count", 32'(if1.count), 0);
      chk("rst_ovf", 32'(if1.overflow), 0);
      chk("rst_unf", 32'(if1.underflow), 0);
      chk("rst_aempty", 32'(if1.almost_empty), 1);
      chk("rst_dout_reg", 32'(if0.data_out), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill, overflow, drain
      for (int i = 0; i < 16; i++) begin
         step(1'b1, 16'(i), 1'b0, 1'b0);
         if (i == 12) chk("afull_at13", 32'(if1.almost_full), 0);
         if (i == 13) chk("afull_at14", 32'(if1.almost_full), 1);
      end
      chk("fill_full", 32'(if1.full), 1);
      chk("fill_count", 32'(if1.count), 16);
      step(1'b1, 16'hDEAD, 1'b0, 1'b0);
      chk("ovf_set", 32'(if1.overflow), 1);
      chk("ovf_count", 32'(if1.count), 16);
      for (int i = 0; i < 16; i++) idle_read();
      chk("drain_empty", 32'(if1.empty), 1);
      chk("ovf_sticky", 32'(if1.overflow), 1);
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("flush_ovf", 32'(if1.overflow), 0);

      // Full with simultaneous read and write
      for (int i = 0; i < 16; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
      step(1'b1, 16'hBEEF, 1'b1, 1'b0);
      chk("rw_full_count", 32'(if1.count), 16);
      chk("rw_full_ovf", 32'(if1.overflow), 0);
      for (int i = 0; i < 16; i++) begin
         idle_read();
         if (i == 12) chk("aempty_at3", 32'(if1.almost_empty), 0);
         if (i == 13) chk("aempty_at2", 32'(if1.almost_empty), 1);
      end
      chk("rw_drain_empty", 32'(if1.empty), 1);

      // Empty with simultaneous read and write
      step(1'b1, 16'h1234, 1'b1, 1'b0);
      chk("unf_set", 32'(if1.underflow), 1);
      chk("unf_count", 32'(if1.count), 1);
      chk("unf_fwft_data", 32'(if1.data_out), 32'h1234);
      idle_read();
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      chk("flush_unf", 32'(if1.underflow), 0);

      // Registered read latency and hold
      step(1'b1, 16'hA5A5, 1'b0, 1'b0);
      idle_read();
      chk("reg_dout_next", 32'(if0.data_out), 32'hA5A5);
      idle();
      idle();
      chk("reg_dout_hold", 32'(if0.data_out), 32'hA5A5);

      // Flush beats a same-cycle write
      for (int i = 0; i < 17; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
      for (int i = 0; i < 11; i++) idle_read();
      chk("pre_flush_count", 32'(if1.count), 5);
      chk("pre_flush_ovf", 32'(if1.overflow), 1);
      step(1'b1, 16'h7777, 1'b0, 1'b1);
      chk("flush_count", 32'(if1.count), 0);
      chk("flush_empty", 32'(if1.empty), 1);
      chk("flush_ovf2", 32'(if1.overflow), 0);

      // Busy random traffic so both pointers wrap
      for (int i = 0; i < 40; i++) begin
         step(($urandom_range(0, 99) < 85), 16'($urandom), ($urandom_range(0, 99) < 85), 1'b0);
         chk("rnd_count", 32'(if1.count), 32'(model_q.size()));
         chk("rnd_ovf", 32'(if1.overflow), 32'(m_ovf));
         chk("rnd_unf", 32'(if1.underflow), 32'(m_unf));
      end
      while (model_q.size() > 0) idle_read();
      idle();

      // Asynchronous reset mid-operation
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      model_q.delete();
      #1;
      chk("async_rst_count", 32'(if1.count), 0);
      chk("async_rst_empty", 32'(if1.empty), 1);
      @(negedge clk);
      rst_n = 1'b1;
      idle();
      idle();

      chk("sb_drained1", 32'(exp1.size()), 0);
      chk("sb_drained0", 32'(exp0.size()), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   task automatic idle_read();
      step(1'b0, 16'h0000, 1'b1, 1'b0);
   endtask
endmodule
